// File: rtl/regfile_pkg.sv
// Shared helpers for the multi-port register file: address width,
// lane count, parameter legality and address range test.
package regfile_pkg;

    localparam int MAX_PORTS = 16;

    // Address width: enough bits to name every entry, never less than one.
    function automatic int calc_aw(input int depth);
        int aw;
        aw = $clog2(depth);
        return (aw < 1) ? 1 : aw;
    endfunction

    // Number of independently writable lanes per entry.
    function automatic int calc_lanes(input int width, input int gran);
        return (gran > 0) ? (width / gran) : 1;
    endfunction

    // True when the parameter set describes a buildable register file.
    function automatic bit params_ok(input int depth, input int width,
                                     input int num_read, input int num_write,
                                     input int gran, input int bypass);
        return (depth >= 2) && (gran >= 1) && (width >= gran) &&
               ((width % gran) == 0) &&
               (num_read >= 1) && (num_read <= MAX_PORTS) &&
               (num_write >= 1) && (num_write <= MAX_PORTS) &&
               ((bypass == 0) || (bypass == 1));
    endfunction

    // Addresses at or above the depth name no entry.
    function automatic logic addr_in_range(input int unsigned addr,
                                           input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/regfile_lane_merge.sv
// Resolves all write ports against one address: per lane, reports whether
// any port writes it and which data wins (highest port index wins).
module regfile_lane_merge
    import regfile_pkg::*;
#(
    parameter int DEPTH     = 128,
    parameter int WIDTH     = 64,
    parameter int NUM_WRITE = 8,
    parameter int MASK_GRAN = 8,
    localparam int AW       = calc_aw(DEPTH),
    localparam int LANES    = calc_lanes(WIDTH, MASK_GRAN)
) (
    input  logic [AW-1:0]              i_addr,
    input  logic [NUM_WRITE-1:0]       i_wr_en,
    input  logic [NUM_WRITE*AW-1:0]    i_wr_addr,
    input  logic [NUM_WRITE*WIDTH-1:0] i_wr_data,
    input  logic [NUM_WRITE*LANES-1:0] i_wr_mask,
    output logic [LANES-1:0]           o_lane_en,
    output logic [WIDTH-1:0]           o_lane_data
);

    // Walk ports in ascending order so a later (higher) port overrides.
    always_comb begin
        o_lane_en   = '0;
        o_lane_data = '0;
        for (int j = 0; j < NUM_WRITE; j++) begin
            if (i_wr_en[j] && (i_wr_addr[j*AW +: AW] == i_addr) &&
                addr_in_range(32'(i_wr_addr[j*AW +: AW]), DEPTH)) begin
                for (int k = 0; k < LANES; k++) begin
                    if (i_wr_mask[j*LANES + k]) begin
                        o_lane_en[k] = 1'b1;
                        o_lane_data[k*MASK_GRAN +: MASK_GRAN] =
                            i_wr_data[j*WIDTH + k*MASK_GRAN +: MASK_GRAN];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// Multi-port register file: NUM_WRITE lane-masked write ports with
// highest-port-wins priority, NUM_READ one-cycle read ports with optional
// write-to-read forwarding, and per-lane written bits so unwritten lanes
// read as zero without clearing the storage itself.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DEPTH     = 128,
    parameter int WIDTH     = 64,
    parameter int NUM_READ  = 8,
    parameter int NUM_WRITE = 8,
    parameter int MASK_GRAN = 8,
    parameter int BYPASS    = 1,
    localparam int AW       = calc_aw(DEPTH),
    localparam int LANES    = calc_lanes(WIDTH, MASK_GRAN)
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [NUM_READ-1:0]        i_rd_en,
    input  logic [NUM_READ*AW-1:0]     i_rd_addr,
    output logic [NUM_READ*WIDTH-1:0]  o_rd_data,
    output logic [NUM_READ-1:0]        o_rd_valid,
    input  logic [NUM_WRITE-1:0]       i_wr_en,
    input  logic [NUM_WRITE*AW-1:0]    i_wr_addr,
    input  logic [NUM_WRITE*WIDTH-1:0] i_wr_data,
    input  logic [NUM_WRITE*LANES-1:0] i_wr_mask,
    output logic [NUM_WRITE-1:0]       o_wr_conflict
);

    if (!params_ok(DEPTH, WIDTH, NUM_READ, NUM_WRITE, MASK_GRAN, BYPASS)) begin : g_param_error
        $error("regfile_multiport: illegal parameter combination");
    end

    logic [WIDTH-1:0] r_mem      [DEPTH];
    logic [LANES-1:0] r_written  [DEPTH];
    logic [WIDTH-1:0] r_rd_data  [NUM_READ];
    logic [NUM_READ-1:0]  r_rd_valid;
    logic [NUM_WRITE-1:0] r_conflict;

    logic [LANES-1:0] w_ent_en   [DEPTH];
    logic [WIDTH-1:0] w_ent_data [DEPTH];
    logic [LANES-1:0] w_byp_en   [NUM_READ];
    logic [WIDTH-1:0] w_byp_data [NUM_READ];
    logic [WIDTH-1:0] w_rd_next  [NUM_READ];
    logic [NUM_WRITE-1:0] w_conf_next;

    // Per-entry write resolution.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        regfile_lane_merge #(
            .DEPTH     (DEPTH),
            .WIDTH     (WIDTH),
            .NUM_WRITE (NUM_WRITE),
            .MASK_GRAN (MASK_GRAN)
        ) u_wr_merge (
            .i_addr      (AW'(gi)),
            .i_wr_en     (i_wr_en),
            .i_wr_addr   (i_wr_addr),
            .i_wr_data   (i_wr_data),
            .i_wr_mask   (i_wr_mask),
            .o_lane_en   (w_ent_en[gi]),
            .o_lane_data (w_ent_data[gi])
        );
    end

    // Per-read-port forwarding view of this cycle's writes.
    for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_bypass
        regfile_lane_merge #(
            .DEPTH     (DEPTH),
            .WIDTH     (WIDTH),
            .NUM_WRITE (NUM_WRITE),
            .MASK_GRAN (MASK_GRAN)
        ) u_byp_merge (
            .i_addr      (i_rd_addr[gi*AW +: AW]),
            .i_wr_en     (i_wr_en),
            .i_wr_addr   (i_wr_addr),
            .i_wr_data   (i_wr_data),
            .i_wr_mask   (i_wr_mask),
            .o_lane_en   (w_byp_en[gi]),
            .o_lane_data (w_byp_data[gi])
        );
    end

    // Storage lanes commit from the resolved enables; no reset, and blocked
    // while reset is held so nothing presented during reset lands.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                for (int k = 0; k < LANES; k++) begin
                    if (w_ent_en[e][k]) begin
                        r_mem[e][k*MASK_GRAN +: MASK_GRAN] <= w_ent_data[e][k*MASK_GRAN +: MASK_GRAN];
                    end
                end
            end
        end
    end

    // Written bits: set by any committed lane, cleared only by reset.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                r_written[e] <= '0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                r_written[e] <= r_written[e] | w_ent_en[e];
            end
        end
    end

    // Next read word per port: zero when out of range or lane unwritten,
    // forwarded lane when enabled and a write hits it this cycle.
    always_comb begin
        for (int i = 0; i < NUM_READ; i++) begin
            logic [AW-1:0] addr;
            addr         = i_rd_addr[i*AW +: AW];
            w_rd_next[i] = '0;
            if (addr_in_range(32'(addr), DEPTH)) begin
                for (int k = 0; k < LANES; k++) begin
                    if ((BYPASS != 0) && w_byp_en[i][k]) begin
                        w_rd_next[i][k*MASK_GRAN +: MASK_GRAN] = w_byp_data[i][k*MASK_GRAN +: MASK_GRAN];
                    end else if (r_written[addr][k]) begin
                        w_rd_next[i][k*MASK_GRAN +: MASK_GRAN] = r_mem[addr][k*MASK_GRAN +: MASK_GRAN];
                    end
                end
            end
        end
    end

    // A port is flagged when any higher port hits the same entry and lane.
    always_comb begin
        w_conf_next = '0;
        for (int j = 0; j < NUM_WRITE; j++) begin
            for (int m = j + 1; m < NUM_WRITE; m++) begin
                if (i_wr_en[j] && i_wr_en[m] &&
                    (i_wr_addr[j*AW +: AW] == i_wr_addr[m*AW +: AW]) &&
                    addr_in_range(32'(i_wr_addr[j*AW +: AW]), DEPTH) &&
                    ((i_wr_mask[j*LANES +: LANES] & i_wr_mask[m*LANES +: LANES]) != '0)) begin
                    w_conf_next[j] = 1'b1;
                end
            end
        end
    end

    // Registered read data/valid and conflict flags; data holds when idle.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rd_valid <= '0;
            r_conflict <= '0;
            for (int i = 0; i < NUM_READ; i++) begin
                r_rd_data[i] <= '0;
            end
        end else begin
            r_rd_valid <= i_rd_en;
            r_conflict <= w_conf_next;
            for (int i = 0; i < NUM_READ; i++) begin
                if (i_rd_en[i]) begin
                    r_rd_data[i] <= w_rd_next[i];
                end
            end
        end
    end

    // Pack the per-port read registers onto the output bus.
    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            o_rd_data[i*WIDTH +: WIDTH] = r_rd_data[i];
        end
    end

    assign o_rd_valid    = r_rd_valid;
    assign o_wr_conflict = r_conflict;

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport (DEPTH=100 so out-of-range
// addresses exist): stimulus pushes model expectations, a negedge monitor
// pops and compares them against the registered outputs.
module tb_regfile_multiport;
    import regfile_pkg::*;

    localparam int DEPTH  = 100;
    localparam int WIDTH  = 64;
    localparam int NR     = 8;
    localparam int NW     = 8;
    localparam int GRAN   = 8;
    localparam int BYPASS = 1;
    localparam int AW     = calc_aw(DEPTH);
    localparam int LANES  = calc_lanes(WIDTH, GRAN);

    logic                clk;
    logic                rst;
    logic [NR-1:0]       rd_en;
    logic [NR*AW-1:0]    rd_addr;
    logic [NR*WIDTH-1:0] rd_data;
    logic [NR-1:0]       rd_valid;
    logic [NW-1:0]       wr_en;
    logic [NW*AW-1:0]    wr_addr;
    logic [NW*WIDTH-1:0] wr_data;
    logic [NW*LANES-1:0] wr_mask;
    logic [NW-1:0]       wr_conflict;

    regfile_multiport #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .NUM_READ(NR), .NUM_WRITE(NW),
        .MASK_GRAN(GRAN), .BYPASS(BYPASS)
    ) dut (
        .i_clock(clk), .i_reset(rst),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_mask(wr_mask),
        .o_wr_conflict(wr_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Stimulus for the next cycle, in plain per-port form.
    logic             t_rd_en   [NR];
    int               t_rd_addr [NR];
    logic             t_wr_en   [NW];
    int               t_wr_addr [NW];
    logic [WIDTH-1:0] t_wr_data [NW];
    logic [LANES-1:0] t_wr_mask [NW];

    // Reference model: contents, which lanes hold written data, last read word.
    logic [WIDTH-1:0] m_mem  [DEPTH];
    logic [LANES-1:0] m_wm   [DEPTH];
    logic [WIDTH-1:0] m_last [NR];
    logic [WIDTH-1:0] p_mem  [DEPTH];
    logic [LANES-1:0] p_wm   [DEPTH];

    typedef struct {
        int                  due;
        logic [NR-1:0]       valid;
        logic [NR*WIDTH-1:0] data;
        logic [NW-1:0]       conf;
    } exp_t;
    exp_t exp_q[$];
    exp_t me;

    function automatic logic [WIDTH-1:0] lane_expand(input logic [LANES-1:0] wm);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < LANES; k++) if (wm[k]) r[k*GRAN +: GRAN] = '1;
        return r;
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic model_reset();
        for (int e = 0; e < DEPTH; e++) m_wm[e] = '0;
        for (int i = 0; i < NR; i++) m_last[i] = '0;
    endtask

    task automatic clear_ops();
        for (int i = 0; i < NR; i++) begin t_rd_en[i] = 1'b0; t_rd_addr[i] = 0; end
        for (int j = 0; j < NW; j++) begin
            t_wr_en[j] = 1'b0; t_wr_addr[j] = 0; t_wr_data[j] = '0; t_wr_mask[j] = '0;
        end
    endtask

    function automatic int rand_addr();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 11));
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < NR; i++) begin
            t_rd_en[i] = 1'($urandom_range(0, 1)); t_rd_addr[i] = rand_addr();
        end
        for (int j = 0; j < NW; j++) begin
            t_wr_en[j]   = 1'($urandom_range(0, 1));
            t_wr_addr[j] = rand_addr();
            t_wr_data[j] = {$urandom, $urandom};
            t_wr_mask[j] = LANES'($urandom_range(0, 255));
        end
    endtask

    task automatic drive_pins();
        for (int i = 0; i < NR; i++) begin
            rd_en[i] = t_rd_en[i]; rd_addr[i*AW +: AW] = AW'(t_rd_addr[i]);
        end
        for (int j = 0; j < NW; j++) begin
            wr_en[j] = t_wr_en[j]; wr_addr[j*AW +: AW] = AW'(t_wr_addr[j]);
            wr_data[j*WIDTH +: WIDTH] = t_wr_data[j]; wr_mask[j*LANES +: LANES] = t_wr_mask[j];
        end
    endtask

    // Apply one cycle: drive pins, predict the outcome, queue it, advance.
    task automatic step();
        exp_t e;
        logic [WIDTH-1:0] lm;
        drive_pins();
        p_mem = m_mem;
        p_wm  = m_wm;
        // Applying ports in ascending order leaves the highest port's lanes.
        for (int j = 0; j < NW; j++) begin
            if (t_wr_en[j] && t_wr_addr[j] < DEPTH) begin
                lm = lane_expand(t_wr_mask[j]);
                p_mem[t_wr_addr[j]] = (p_mem[t_wr_addr[j]] & ~lm) | (t_wr_data[j] & lm);
                p_wm[t_wr_addr[j]]  = p_wm[t_wr_addr[j]] | t_wr_mask[j];
            end
        end
        e.due = cyc + 1;
        e.data = '0;
        for (int i = 0; i < NR; i++) begin
            e.valid[i] = t_rd_en[i];
            if (t_rd_en[i]) begin
                if (t_rd_addr[i] >= DEPTH) m_last[i] = '0;
                else if (BYPASS != 0)      m_last[i] = p_mem[t_rd_addr[i]] & lane_expand(p_wm[t_rd_addr[i]]);
                else                       m_last[i] = m_mem[t_rd_addr[i]] & lane_expand(m_wm[t_rd_addr[i]]);
            end
            e.data[i*WIDTH +: WIDTH] = m_last[i];
        end
        for (int j = 0; j < NW; j++) begin
            e.conf[j] = 1'b0;
            for (int m = j + 1; m < NW; m++) begin
                if (t_wr_en[j] && t_wr_en[m] && t_wr_addr[j] == t_wr_addr[m] &&
                    t_wr_addr[j] < DEPTH && (t_wr_mask[j] & t_wr_mask[m]) != '0)
                    e.conf[j] = 1'b1;
            end
        end
        exp_q.push_back(e);
        m_mem = p_mem;
        m_wm  = p_wm;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation that has come due.
    always @(negedge clk) begin
        if (!rst) begin
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                me = exp_q.pop_front();
                check("rd_valid", WIDTH'(rd_valid), WIDTH'(me.valid));
                check("wr_conflict", WIDTH'(wr_conflict), WIDTH'(me.conf));
                for (int i = 0; i < NR; i++)
                    check($sformatf("rd_data[%0d]", i), rd_data[i*WIDTH +: WIDTH], me.data[i*WIDTH +: WIDTH]);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    logic [WIDTH-1:0] val_a;
    logic [WIDTH-1:0] val_b;

    initial begin
        rst = 1'b1;
        clear_ops();
        drive_pins();
        model_reset();
        for (int e = 0; e < DEPTH; e++) m_mem[e] = 'x;
        repeat (3) @(posedge clk);
        #1;
        check("reset rd_valid", WIDTH'(rd_valid), '0);
        check("reset rd_data0", rd_data[0 +: WIDTH], '0);
        check("reset wr_conflict", WIDTH'(wr_conflict), '0);
        rst = 1'b0;

        // Read of a never-written entry returns zero with valid.
        clear_ops(); t_rd_en[0] = 1'b1; t_rd_addr[0] = 5; step();
        check("first read valid", WIDTH'(rd_valid[0]), 1);
        check("first read data", rd_data[0 +: WIDTH], '0);
        $display("txn: read addr 5 after reset -> %h", rd_data[0 +: WIDTH]);

        // Partial-lane write.
        clear_ops(); t_wr_en[0] = 1'b1; t_wr_addr[0] = 3;
        t_wr_data[0] = 64'h1122334455667788; t_wr_mask[0] = 8'h0F; step();
        clear_ops(); t_rd_en[1] = 1'b1; t_rd_addr[1] = 3; step();
        check("masked write", rd_data[1*WIDTH +: WIDTH], 64'h0000000055667788);
        $display("txn: masked write addr 3 read back %h", rd_data[1*WIDTH +: WIDTH]);

        // Two ports on one entry: higher port wins and lower port is flagged.
        val_a = {$urandom, $urandom};
        val_b = {$urandom, $urandom};
        clear_ops();
        t_wr_en[2] = 1'b1; t_wr_addr[2] = 9; t_wr_data[2] = val_a; t_wr_mask[2] = 8'hFF;
        t_wr_en[6] = 1'b1; t_wr_addr[6] = 9; t_wr_data[6] = val_b; t_wr_mask[6] = 8'hFF;
        step();
        check("conflict flags", WIDTH'(wr_conflict), 64'h04);
        clear_ops(); t_rd_en[2] = 1'b1; t_rd_addr[2] = 9; step();
        check("priority winner", rd_data[2*WIDTH +: WIDTH], val_b);
        check("conflict one cycle", WIDTH'(wr_conflict), '0);
        $display("txn: W2/W6 collide addr 9 read %h", rd_data[2*WIDTH +: WIDTH]);

        // Same-cycle write and read of one entry forwards the new value.
        clear_ops();
        t_wr_en[4] = 1'b1; t_wr_addr[4] = 7; t_wr_data[4] = 64'hDEAD; t_wr_mask[4] = 8'hFF;
        t_rd_en[3] = 1'b1; t_rd_addr[3] = 7;
        step();
        check("bypass", rd_data[3*WIDTH +: WIDTH], 64'hDEAD);
        $display("txn: bypass addr 7 read %h", rd_data[3*WIDTH +: WIDTH]);

        // Out-of-range write ignored; out-of-range read returns zero, valid.
        clear_ops(); t_wr_en[1] = 1'b1; t_wr_addr[1] = 120;
        t_wr_data[1] = {$urandom, $urandom} | 64'h1; t_wr_mask[1] = 8'hFF; step();
        clear_ops(); t_rd_en[5] = 1'b1; t_rd_addr[5] = 120;
        t_rd_en[6] = 1'b1; t_rd_addr[6] = 20; step();
        check("oob read data", rd_data[5*WIDTH +: WIDTH], '0);
        check("oob read valid", WIDTH'(rd_valid[5]), 1);
        check("alias untouched", rd_data[6*WIDTH +: WIDTH], '0);
        $display("txn: out-of-range addr 120 read %h", rd_data[5*WIDTH +: WIDTH]);

        // Random traffic, then reset in the middle of the stream.
        for (int n = 0; n < 50; n++) begin rand_ops(); step(); end
        rst = 1'b1;
        #1;
        check("midreset rd_valid", WIDTH'(rd_valid), '0);
        check("midreset wr_conflict", WIDTH'(wr_conflict), '0);
        check("midreset rd_data7", rd_data[7*WIDTH +: WIDTH], '0);
        exp_q.delete();
        model_reset();
        rand_ops();
        drive_pins();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int base = 0; base < 128; base += NR) begin
            clear_ops();
            for (int i = 0; i < NR; i++) begin t_rd_en[i] = 1'b1; t_rd_addr[i] = base + i; end
            step();
            for (int i = 0; i < NR; i++)
                check($sformatf("post-reset addr %0d", base + i), rd_data[i*WIDTH +: WIDTH], '0);
            $display("txn: post-reset sweep from addr %0d", base);
        end

        for (int n = 0; n < 400; n++) begin rand_ops(); step(); end
        clear_ops(); step(); step();
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
